pulse_event_arbiter: RTL and testbench

- Collects single-cycle event pulses from EVENT_COUNT independent sources and latches each one as a pending level.
- Presents the pending events one at a time to a single FSM consumer over a valid/ready handshake. Sources are served in round-robin order.
- Clears each source's pending latch on acceptance and flags overruns.
- Sits between status/interrupt pulse sources (MAC, FIFO, parser events) and the switch control FSM. It replaces ad-hoc per-event pulse latches and their hand-written clear logic.

---
 rtl/pulse_event_arbiter_pkg.sv | 11 +
 rtl/pulse_event_arbiter_if.sv | 25 ++
 rtl/pulse_event_arbiter_event_capture.sv | 41 ++++
 rtl/pulse_event_arbiter.sv | 131 +++++++++++++
 tb/tb_pulse_event_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_event_arbiter_pkg.sv
// Shared definitions for the pulse event arbiter.
// Holds the arbitration FSM state encoding used by the top level.
package pulse_event_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_ARB   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pulse_event_arbiter_if.sv
// Event handshake between the arbiter and its single FSM consumer.
//   event_valid : an event is offered (arbiter -> consumer)
//   event_index : source number of the offered event (arbiter -> consumer)
//   event_ready : consumer accepts the offered event this cycle (consumer -> arbiter)
interface pulse_event_arbiter_if #(
    parameter int unsigned INDEX_WIDTH = 2
) ();

    logic                   event_valid;
    logic [INDEX_WIDTH-1:0] event_index;
    logic                   event_ready;

    modport master (
        output event_valid,
        output event_index,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_index,
        output event_ready
    );

endinterface

// File: rtl/pulse_event_arbiter_event_capture.sv
// Per-source pending/overrun latch.
//   clock, reset_n : clock and asynchronous active-low reset
//   event_pulse    : source pulse, each high cycle is one event
//   accept         : the pending event of this source is accepted this cycle
//   overrun_clear  : clears the sticky overrun bit
//   pending        : latched event awaiting acceptance
//   overrun        : sticky, a pulse arrived while an unaccepted event was pending
module pulse_event_arbiter_event_capture (
    input  logic clock,
    input  logic reset_n,
    input  logic event_pulse,
    input  logic accept,
    input  logic overrun_clear,
    output logic pending,
    output logic overrun
);

    logic pending_q, pending_d;
    logic overrun_q, overrun_d;

    always_comb begin
        // A pulse coinciding with acceptance re-arms the latch, so the new event survives.
        pending_d = event_pulse | (pending_q & ~accept);
        // Setting wins over a simultaneous clear.
        overrun_d = (event_pulse & pending_q & ~accept) | (overrun_q & ~overrun_clear);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/pulse_event_arbiter.sv
// Collects single-cycle event pulses from EVENT_COUNT sources, latches them as
// pending levels and offers them one at a time, round-robin, to one consumer.
//   clock, reset_n : clock and asynchronous active-low reset
//   event_pulse    : per-source event pulses
//   event_mask     : 1 = source eligible for grant (masked events still latch)
//   pending        : current latch state, unmasked
//   overrun        : sticky per-source overrun flags
//   overrun_clear  : per-bit clear of overrun
//   evt            : valid/index/ready handshake toward the consumer
module pulse_event_arbiter
    import pulse_event_arbiter_pkg::*;
#(
    parameter int unsigned EVENT_COUNT = 4,
    parameter int unsigned INDEX_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [EVENT_COUNT-1:0] event_pulse,
    input  logic [EVENT_COUNT-1:0] event_mask,
    output logic [EVENT_COUNT-1:0] pending,
    output logic [EVENT_COUNT-1:0] overrun,
    input  logic [EVENT_COUNT-1:0] overrun_clear,
    pulse_event_arbiter_if.master  evt
);

    if (EVENT_COUNT < 2 || EVENT_COUNT > 32 || INDEX_WIDTH != $clog2(EVENT_COUNT)) begin : g_param_check
        $error("pulse_event_arbiter: EVENT_COUNT must be 2..32 and INDEX_WIDTH must equal clog2(EVENT_COUNT)");
    end

    // First set bit at or above ptr, wrapping modulo EVENT_COUNT.
    function automatic logic [INDEX_WIDTH-1:0] rr_pick(
        input logic [EVENT_COUNT-1:0] elig,
        input logic [INDEX_WIDTH-1:0] ptr
    );
        logic [INDEX_WIDTH-1:0] pick;
        logic                   found;
        int unsigned            idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < EVENT_COUNT; k++) begin
            idx = (32'(ptr) + k) % EVENT_COUNT;
            if (!found && elig[idx]) begin
                pick  = idx[INDEX_WIDTH-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    arb_state_e             state_q, state_d;
    logic                   valid_q, valid_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic                   accept;
    logic [EVENT_COUNT-1:0] accept_vec;
    logic [EVENT_COUNT-1:0] eligible;

    assign eligible = pending & event_mask;
    // valid_q is only high in OFFER, so this is the handshake completing.
    assign accept   = valid_q & evt.event_ready;

    always_comb begin
        accept_vec = '0;
        if (accept) begin
            accept_vec[index_q] = 1'b1;
        end
    end

    for (genvar i = 0; i < EVENT_COUNT; i++) begin : g_capture
        pulse_event_arbiter_event_capture u_capture (
            .clock         (clock),
            .reset_n       (reset_n),
            .event_pulse   (event_pulse[i]),
            .accept        (accept_vec[i]),
            .overrun_clear (overrun_clear[i]),
            .pending       (pending[i]),
            .overrun       (overrun[i])
        );
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    index_d = rr_pick(eligible, ptr_q);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Index and valid are frozen until the consumer takes the event.
                if (evt.event_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = (32'(index_q) == EVENT_COUNT - 1) ? '0 : index_q + 1'b1;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // Gap cycle: lets the cleared pending bit and new pointer settle.
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    assign evt.event_valid = valid_q;
    assign evt.event_index = index_q;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
module tb_pulse_event_arbiter;

    logic       clock;
    logic       reset_n;
    logic [3:0] event_pulse;
    logic [3:0] event_mask;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [3:0] overrun_clear;

    pulse_event_arbiter_if #(.INDEX_WIDTH(2)) evt ();

    pulse_event_arbiter #(
        .EVENT_COUNT (4),
        .INDEX_WIDTH (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .event_pulse   (event_pulse),
        .event_mask    (event_mask),
        .pending       (pending),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .evt           (evt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_compared;
    int n_mismatched;
    int exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the expected index on each handshake and checks the offer stays frozen.
    logic       prev_valid;
    logic       prev_ready;
    logic [1:0] prev_index;
    initial begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_index = '0;
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(evt.event_valid), 32'h1);
                chk("hold_index", 32'(evt.event_index), 32'(prev_index));
            end
            if (evt.event_valid && evt.event_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL accept_index: got %0d required no accept at %0t", evt.event_index, $time);
                end else begin
                    chk("accept_index", 32'(evt.event_index), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = evt.event_valid;
            prev_ready = evt.event_ready;
            prev_index = evt.event_index;
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Pulse all four sources with ready high; expect 0,1,2,3 at 3-cycle spacing.
    task automatic burst_all();
        logic [3:0] pend_exp;
        pend_exp = 4'b1111;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        evt.event_ready = 1'b1;
        event_pulse = 4'b1111;
        tick();
        event_pulse = 4'b0000;
        chk("rr_pending_set", 32'(pending), 32'hF);
        chk("rr_valid_lat", 32'(evt.event_valid), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rr_valid_on", 32'(evt.event_valid), 32'h1);
            chk("rr_index", 32'(evt.event_index), 32'(i));
            tick();
            pend_exp[i] = 1'b0;
            chk("rr_valid_arb", 32'(evt.event_valid), 32'h0);
            chk("rr_pending_clr", 32'(pending), 32'(pend_exp));
            tick();
            chk("rr_valid_idle", 32'(evt.event_valid), 32'h0);
            tick();
        end
        evt.event_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        reset_n         = 1'b0;
        event_pulse     = 4'b0000;
        event_mask      = 4'b1111;
        overrun_clear   = 4'b0000;
        evt.event_ready = 1'b0;

        tick();
        tick();
        chk("rst_valid",   32'(evt.event_valid), 32'h0);
        chk("rst_index",   32'(evt.event_index), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        tick();

        // Single pulse, held offer, then accept.
        exp_q.push_back(2);
        event_pulse = 4'b0100;
        tick();
        event_pulse = 4'b0000;
        chk("single_pending", 32'(pending), 32'h4);
        chk("single_valid_lat", 32'(evt.event_valid), 32'h0);
        tick();
        chk("single_valid", 32'(evt.event_valid), 32'h1);
        chk("single_index", 32'(evt.event_index), 32'h2);
        for (int i = 0; i < 10; i++) tick();
        chk("single_hold_valid", 32'(evt.event_valid), 32'h1);
        chk("single_hold_index", 32'(evt.event_index), 32'h2);
        evt.event_ready = 1'b1;
        tick();
        evt.event_ready = 1'b0;
        chk("single_pending_clr", 32'(pending), 32'h0);
        chk("single_valid_arb", 32'(evt.event_valid), 32'h0);
        tick();
        tick();

        // Round robin from pointer 0, twice (pointer wraps 3 -> 0).
        do_reset();
        burst_all();
        burst_all();

        // Masking: source 0 masked stays pending until unmasked.
        exp_q.push_back(1);
        exp_q.push_back(0);
        event_mask  = 4'b1110;
        event_pulse = 4'b0011;
        tick();
        event_pulse = 4'b0000;
        tick();
        chk("mask_valid", 32'(evt.event_valid), 32'h1);
        chk("mask_index", 32'(evt.event_index), 32'h1);
        evt.event_ready = 1'b1;
        tick();
        evt.event_ready = 1'b0;
        chk("mask_pending", 32'(pending), 32'h1);
        tick();
        tick();
        chk("mask_no_offer", 32'(evt.event_valid), 32'h0);
        chk("mask_still_pending", 32'(pending), 32'h1);
        event_mask = 4'b1111;
        tick();
        chk("unmask_valid", 32'(evt.event_valid), 32'h1);
        chk("unmask_index", 32'(evt.event_index), 32'h0);
        evt.event_ready = 1'b1;
        tick();
        evt.event_ready = 1'b0;
        chk("unmask_pending_clr", 32'(pending), 32'h0);
        tick();
        tick();

        // Pulse coinciding with acceptance of the same source.
        exp_q.push_back(1);
        exp_q.push_back(1);
        event_pulse = 4'b0010;
        tick();
        event_pulse = 4'b0000;
        tick();
        chk("coinc_index", 32'(evt.event_index), 32'h1);
        evt.event_ready = 1'b1;
        event_pulse     = 4'b0010;
        tick();
        evt.event_ready = 1'b0;
        event_pulse     = 4'b0000;
        chk("coinc_pending", 32'(pending), 32'h2);
        chk("coinc_overrun", 32'(overrun), 32'h0);
        tick();
        tick();
        chk("coinc_reoffer_valid", 32'(evt.event_valid), 32'h1);
        chk("coinc_reoffer_index", 32'(evt.event_index), 32'h1);
        evt.event_ready = 1'b1;
        tick();
        evt.event_ready = 1'b0;
        chk("coinc_pending_clr", 32'(pending), 32'h0);
        tick();
        tick();

        // Overrun on source 3, set-over-clear, then clear alone.
        exp_q.push_back(3);
        event_pulse = 4'b1000;
        tick();
        event_pulse = 4'b0000;
        tick();
        chk("ovr_index", 32'(evt.event_index), 32'h3);
        event_pulse = 4'b1000;
        tick();
        event_pulse = 4'b0000;
        chk("ovr_set", 32'(overrun), 32'h8);
        chk("ovr_pending", 32'(pending), 32'h8);
        event_pulse   = 4'b1000;
        overrun_clear = 4'b1000;
        tick();
        event_pulse   = 4'b0000;
        overrun_clear = 4'b0000;
        chk("ovr_set_wins", 32'(overrun), 32'h8);
        overrun_clear = 4'b1000;
        tick();
        overrun_clear = 4'b0000;
        chk("ovr_cleared", 32'(overrun), 32'h0);
        evt.event_ready = 1'b1;
        tick();
        evt.event_ready = 1'b0;
        chk("ovr_pending_clr", 32'(pending), 32'h0);
        tick();
        tick();
        chk("ovr_idle", 32'(evt.event_valid), 32'h0);

        // Asynchronous reset while an offer is outstanding.
        event_pulse = 4'b0101;
        tick();
        event_pulse = 4'b0100;
        tick();
        event_pulse = 4'b0000;
        chk("arst_pre_valid", 32'(evt.event_valid), 32'h1);
        chk("arst_pre_index", 32'(evt.event_index), 32'h0);
        chk("arst_pre_overrun", 32'(overrun), 32'h4);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evt.event_valid), 32'h0);
        chk("arst_pending", 32'(pending), 32'h0);
        chk("arst_overrun", 32'(overrun), 32'h0);
        chk("arst_index", 32'(evt.event_index), 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("arst_no_offer", 32'(evt.event_valid), 32'h0);
        chk("arst_no_pending", 32'(pending), 32'h0);
        exp_q.push_back(1);
        event_pulse = 4'b0010;
        tick();
        event_pulse = 4'b0000;
        tick();
        chk("arst_new_valid", 32'(evt.event_valid), 32'h1);
        chk("arst_new_index", 32'(evt.event_index), 32'h1);
        evt.event_ready = 1'b1;
        tick();
        evt.event_ready = 1'b0;
        tick();
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
